// File: rtl/lap_stopwatch_pkg.sv
// Shared types and constants for the lap stopwatch: the packed BCD time
// record, the per-field limits and a couple of BCD helper functions.
package stopwatch_pkg;

  typedef struct packed {
    logic [7:0] min;
    logic [7:0] sec;
    logic [7:0] cs;
  } bcd_time_t;

  localparam logic [7:0] CS_MAX  = 8'h99;
  localparam logic [7:0] SEC_MAX = 8'h59;

  localparam bcd_time_t BCD_ZERO_TIME = '{min: 8'h00, sec: 8'h00, cs: 8'h00};

  // Increment a two-digit BCD value; callers handle the wrap at their own limit
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    else                r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  // Convert a small integer (0..99) into two BCD digits, used for elaboration-time limits
  function automatic logic [7:0] int_to_bcd(input int unsigned v);
    return {4'((v / 10) % 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/lap_stopwatch_if.sv
// Button inputs and display/status outputs of the lap stopwatch, bundled so
// the top level and its bench share one definition. The stopwatch is the
// slave side; whoever presses buttons and reads the digits is the master.
interface lap_stopwatch_if;

  logic       w_button_start;
  logic       w_button_lap;
  logic       w_button_view;

  logic       running;
  logic [7:0] live_min;
  logic [7:0] live_sec;
  logic [7:0] live_cs;
  logic [3:0] view_idx;
  logic [7:0] view_min;
  logic [7:0] view_sec;
  logic [7:0] view_cs;
  logic [3:0] lap_count;
  logic       lap_full;

  modport master (
    output w_button_start, w_button_lap, w_button_view,
    input  running, live_min, live_sec, live_cs, view_idx,
    input  view_min, view_sec, view_cs, lap_count, lap_full
  );

  modport slave (
    input  w_button_start, w_button_lap, w_button_view,
    output running, live_min, live_sec, live_cs, view_idx,
    output view_min, view_sec, view_cs, lap_count, lap_full
  );

endinterface

// File: rtl/lap_stopwatch_counter.sv
// Cascaded BCD minutes:seconds:centiseconds counter. Advances one centisecond
// per tick, wraps minutes after MIN_MAX back to 00:00:00. A synchronous clear
// beats a coincident tick so the value restarts from exactly zero.
module sw_time_counter
  import stopwatch_pkg::*;
#(
  parameter int MIN_MAX = 99
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      clear,
  input  logic      tick,
  output bcd_time_t o_time
);

  localparam logic [7:0] MIN_LAST = int_to_bcd(MIN_MAX);

  bcd_time_t r_time;

  // Ripple the carry cs -> sec -> min on each tick, keeping every field valid BCD
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_time <= BCD_ZERO_TIME;
    end else if (clear) begin
      r_time <= BCD_ZERO_TIME;
    end else if (tick) begin
      if (r_time.cs != CS_MAX) begin
        r_time.cs <= bcd_inc(r_time.cs);
      end else begin
        r_time.cs <= 8'h00;
        if (r_time.sec != SEC_MAX) begin
          r_time.sec <= bcd_inc(r_time.sec);
        end else begin
          r_time.sec <= 8'h00;
          if (r_time.min != MIN_LAST) r_time.min <= bcd_inc(r_time.min);
          else                        r_time.min <= 8'h00;
        end
      end
    end
  end

  assign o_time = r_time;

endmodule

// File: rtl/lap_stopwatch.sv
// Lap stopwatch top level: button synchronisers, centisecond prescaler, live
// BCD time counter, lap memory and the view selector.
// Optional macro LAP_SPLIT_DELTA_EN: when defined, a second counter measures
// the time since the previous lap and laps store that split instead of the
// absolute live time.
module lap_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int CLK_DIV = 500000,
  parameter int LAPS    = 4,
  parameter int MIN_MAX = 99
) (
  input  logic           clk,
  input  logic           reset,
  lap_stopwatch_if.slave bus
);

  localparam int             PW         = $clog2(CLK_DIV);
  localparam logic [PW-1:0]  PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [3:0]     LAPS_W     = 4'(LAPS);

  logic [2:0]    r_sync1;
  logic [2:0]    r_sync2;
  logic [2:0]    r_prev;
  logic [PW-1:0] r_presc;
  logic          r_running;
  logic [3:0]    r_lap_count;
  logic [3:0]    r_view_idx;
  bcd_time_t     r_view_data;
  bcd_time_t     r_slot [1:LAPS];

  logic [2:0]    w_evt;
  logic          w_start_evt;
  logic          w_lap_evt;
  logic          w_view_evt;
  logic          w_start_ok;
  logic          w_lap_store;
  logic          w_clear;
  logic          w_view_ok;
  logic          w_tick;
  logic [3:0]    w_slot_idx;
  bcd_time_t     w_live_time;
  bcd_time_t     w_store_time;

  // Two-flop synchronisers with inversion (pressed = 1) plus a delayed copy for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= ~{bus.w_button_view, bus.w_button_lap, bus.w_button_start};
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Start beats lap beats view; a lower-priority event in the same cycle is simply dropped
  assign w_evt       = r_sync2 & ~r_prev;
  assign w_start_evt = w_evt[0];
  assign w_lap_evt   = w_evt[1] & ~w_evt[0];
  assign w_view_evt  = w_evt[2] & ~w_evt[1] & ~w_evt[0];

  assign w_start_ok  = w_start_evt && (r_view_idx == 4'd0);
  assign w_lap_store = w_lap_evt && r_running && (r_lap_count < LAPS_W);
  assign w_clear     = w_lap_evt && !r_running;
  assign w_view_ok   = w_view_evt && !r_running;
  assign w_tick      = r_running && (r_presc == PRESC_LAST);
  assign w_slot_idx  = r_lap_count + 4'd1;

  // Centisecond prescaler: free-runs while running, parked at zero otherwise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_presc <= '0;
    end else if (w_clear || !r_running || (r_presc == PRESC_LAST)) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  sw_time_counter #(.MIN_MAX(MIN_MAX)) u_live (
    .clk    (clk),
    .reset  (reset),
    .clear  (w_clear),
    .tick   (w_tick),
    .o_time (w_live_time)
  );

`ifdef LAP_SPLIT_DELTA_EN
  bcd_time_t w_split_time;

  sw_time_counter #(.MIN_MAX(MIN_MAX)) u_split (
    .clk    (clk),
    .reset  (reset),
    .clear  (w_clear | w_lap_store),
    .tick   (w_tick),
    .o_time (w_split_time)
  );

  assign w_store_time = w_split_time;
`else
  assign w_store_time = w_live_time;
`endif

  // Run state, lap memory, view selection and the registered slot readout
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_running   <= 1'b0;
      r_lap_count <= '0;
      r_view_idx  <= '0;
      r_view_data <= BCD_ZERO_TIME;
      for (int i = 1; i <= LAPS; i++) r_slot[i] <= BCD_ZERO_TIME;
    end else begin
      r_view_data <= (r_view_idx == 4'd0) ? BCD_ZERO_TIME : r_slot[r_view_idx];
      if (w_start_ok) r_running <= ~r_running;
      if (w_lap_store) begin
        r_slot[w_slot_idx] <= w_store_time;
        r_lap_count        <= w_slot_idx;
      end
      if (w_clear) begin
        r_lap_count <= '0;
        r_view_idx  <= '0;
        for (int i = 1; i <= LAPS; i++) r_slot[i] <= BCD_ZERO_TIME;
      end
      if (w_view_ok) r_view_idx <= (r_view_idx == LAPS_W) ? 4'd0 : r_view_idx + 4'd1;
    end
  end

  assign bus.running   = r_running;
  assign bus.live_min  = w_live_time.min;
  assign bus.live_sec  = w_live_time.sec;
  assign bus.live_cs   = w_live_time.cs;
  assign bus.view_idx  = r_view_idx;
  assign bus.view_min  = (r_view_idx == 4'd0) ? w_live_time.min : r_view_data.min;
  assign bus.view_sec  = (r_view_idx == 4'd0) ? w_live_time.sec : r_view_data.sec;
  assign bus.view_cs   = (r_view_idx == 4'd0) ? w_live_time.cs  : r_view_data.cs;
  assign bus.lap_count = r_lap_count;
  assign bus.lap_full  = (r_lap_count == LAPS_W);

endmodule

// File: tb/tb_lap_stopwatch.sv
// Bench for lap_stopwatch: an integer-centisecond reference model checked
// every cycle, plus literal expectations at the key points of each scenario.
module tb_lap_stopwatch;
  import stopwatch_pkg::*;

  localparam int CLK_DIV = 4;
  localparam int LAPS    = 2;
  localparam int MIN_MAX = 1;
  localparam int WRAP    = (MIN_MAX + 1) * 6000;

`ifdef LAP_SPLIT_DELTA_EN
  localparam logic [23:0] SLOT2_EXP = 24'h000015;
`else
  localparam logic [23:0] SLOT2_EXP = 24'h000025;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  bit   chkEn = 1'b0;
  int   nCompared   = 0;
  int   nMismatched = 0;

  lap_stopwatch_if bus();

  lap_stopwatch #(.CLK_DIV(CLK_DIV), .LAPS(LAPS), .MIN_MAX(MIN_MAX)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model state: times held as plain centisecond counts
  bit [2:0] mH1, mH2, mH3;
  bit       mRunning;
  bit       mViewFresh;
  int       mTime, mSplit, mPhase, mCount, mView;
  int       mSlot [1:LAPS];

  function automatic logic [7:0] bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [23:0] toBcdTime(input int t);
    return {bcd2(t / 6000), bcd2((t / 100) % 60), bcd2(t % 100)};
  endfunction

  function automatic logic [23:0] liveNow();
    return {bus.live_min, bus.live_sec, bus.live_cs};
  endfunction

  function automatic logic [23:0] viewNow();
    return {bus.view_min, bus.view_sec, bus.view_cs};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: button edges seen two-to-three clocks late, then the stopwatch rules in integer time
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mH1 = '0; mH2 = '0; mH3 = '0;
      mRunning = 1'b0; mViewFresh = 1'b0;
      mTime = 0; mSplit = 0; mPhase = 0; mCount = 0; mView = 0;
      for (int i = 1; i <= LAPS; i++) mSlot[i] = 0;
    end else begin
      bit [2:0] ev;
      bit tick, doStart, doLap, doView, clr, store;
      ev      = mH2 & ~mH3;
      tick    = mRunning && (mPhase == CLK_DIV - 1);
      doStart = ev[0];
      doLap   = ev[1] && !ev[0];
      doView  = ev[2] && !ev[1] && !ev[0];
      store   = doLap && mRunning && (mCount < LAPS);
      clr     = doLap && !mRunning;
      mViewFresh = 1'b0;
      if (clr) begin
        mTime = 0; mSplit = 0; mPhase = 0; mCount = 0; mView = 0;
        for (int i = 1; i <= LAPS; i++) mSlot[i] = 0;
      end else begin
        if (store) begin
          mCount = mCount + 1;
`ifdef LAP_SPLIT_DELTA_EN
          mSlot[mCount] = mSplit;
`else
          mSlot[mCount] = mTime;
`endif
        end
        if (tick) mTime = (mTime + 1) % WRAP;
        if (store)     mSplit = 0;
        else if (tick) mSplit = (mSplit + 1) % WRAP;
        mPhase = mRunning ? ((mPhase == CLK_DIV - 1) ? 0 : mPhase + 1) : 0;
        if (doStart && mView == 0) mRunning = !mRunning;
        if (doView && !mRunning) begin
          mView = (mView == LAPS) ? 0 : mView + 1;
          mViewFresh = 1'b1;
        end
      end
      mH3 = mH2;
      mH2 = mH1;
      mH1 = ~{bus.w_button_view, bus.w_button_lap, bus.w_button_start};
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (rst_n && chkEn) begin
      checkOutput("state",
        {30'd0, bus.running, liveNow(), bus.view_idx, bus.lap_count, bus.lap_full},
        {30'd0, mRunning, toBcdTime(mTime), 4'(mView), 4'(mCount), (mCount == LAPS)});
      if (mView == 0)
        checkOutput("view_live", {40'd0, viewNow()}, {40'd0, toBcdTime(mTime)});
      else if (!mViewFresh)
        checkOutput("view_slot", {40'd0, viewNow()}, {40'd0, toBcdTime(mSlot[mView])});
    end
  end

  // Press the selected buttons (bit0 start, bit1 lap, bit2 view) from a negedge; returns on a negedge
  task automatic applyStimulus(input bit [2:0] btn);
    {bus.w_button_view, bus.w_button_lap, bus.w_button_start} = ~btn;
    repeat (3) @(negedge clk);
    {bus.w_button_view, bus.w_button_lap, bus.w_button_start} = 3'b111;
    @(negedge clk);
  endtask

  task automatic waitLive(input logic [23:0] target, input int budget);
    int n;
    n = 0;
    while (liveNow() !== target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (liveNow() !== target) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL wait_live: got %h, expected %h (timeout)", liveNow(), target);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    {bus.w_button_view, bus.w_button_lap, bus.w_button_start} = 3'b111;
    repeat (2) @(negedge clk);
    checkOutput("reset_state",
      {bus.running, liveNow(), bus.view_idx, viewNow(), bus.lap_count, bus.lap_full}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    chkEn = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] basic count");
    applyStimulus(3'b001);
    repeat (399) @(posedge clk);
    @(negedge clk);
    checkOutput("basic_live_100", {40'd0, liveNow()}, 64'h000100);
    applyStimulus(3'b001);
    repeat (100) @(posedge clk);
    @(negedge clk);
    checkOutput("basic_hold", {39'd0, bus.running, liveNow()}, 64'h000100);
    applyStimulus(3'b010);
    checkOutput("basic_clear", {36'd0, liveNow(), bus.lap_count}, 64'h0);

    $display("[TB] laps and overflow");
    applyStimulus(3'b001);
    waitLive(24'h000010, 200);
    applyStimulus(3'b010);
    waitLive(24'h000025, 200);
    applyStimulus(3'b010);
    waitLive(24'h000040, 200);
    applyStimulus(3'b010);
    checkOutput("laps_full", {59'd0, bus.lap_count, bus.lap_full}, 64'h5);

    $display("[TB] view cycle");
    applyStimulus(3'b001);
    applyStimulus(3'b100);
    checkOutput("view_slot1", {36'd0, bus.view_idx, viewNow()}, 64'h1000010);
    applyStimulus(3'b001);
    checkOutput("start_ignored", {63'd0, bus.running}, 64'h0);
    applyStimulus(3'b100);
    checkOutput("view_slot2", {36'd0, bus.view_idx, viewNow()}, {36'd0, 4'd2, SLOT2_EXP});
    applyStimulus(3'b100);
    checkOutput("view_back_live", {60'd0, bus.view_idx}, 64'h0);

    $display("[TB] simultaneous events and clear");
    applyStimulus(3'b011);
    checkOutput("start_over_lap", {59'd0, bus.running, bus.lap_count}, 64'h12);
    applyStimulus(3'b001);
    applyStimulus(3'b010);
    checkOutput("clear_all", {35'd0, liveNow(), bus.lap_count, bus.lap_full}, 64'h0);
    applyStimulus(3'b100);
    checkOutput("cleared_slot1", {36'd0, bus.view_idx, viewNow()}, 64'h1000000);
    applyStimulus(3'b100);
    checkOutput("cleared_slot2", {36'd0, bus.view_idx, viewNow()}, 64'h2000000);
    applyStimulus(3'b100);

    $display("[TB] async reset mid-run");
    applyStimulus(3'b001);
    waitLive(24'h000020, 200);
    applyStimulus(3'b010);
    waitLive(24'h000100, 500);
    applyStimulus(3'b010);
    waitLive(24'h000347, 1200);
    #2 rst_n = 1'b0;
    #1 checkOutput("async_reset",
      {bus.running, liveNow(), bus.view_idx, viewNow(), bus.lap_count, bus.lap_full}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] minute rollover");
    applyStimulus(3'b001);
    repeat (47995) @(posedge clk);
    @(negedge clk);
    checkOutput("roll_last", {40'd0, liveNow()}, 64'h015999);
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("roll_wrap", {40'd0, liveNow()}, 64'h000000);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
